alu_regfile: RTL and testbench

Execute-stage core of the single-cycle RISC-V datapath. It holds the 32-entry integer register file and the 4-bit-opcode ALU. The ALU's first operand is rs1. Its second operand is either rs2 or a pre-decoded immediate. It exposes the read data, the ALU result and the zero flag for memory access, write-back and branch decisions.

---
 rtl/alu_regfile_pkg.sv | 20 ++
 rtl/alu_regfile_if.sv | 34 +++
 rtl/alu_regfile_alu_unit.sv | 40 ++++
 rtl/alu_regfile.sv | 70 +++++++
 tb/tb_alu_regfile.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_regfile_pkg.sv
// Shared definitions for the execute stage: ALU opcode encodings and the
// default datapath width. The control unit imports the same constants so
// decode and execute always agree on the opcode values.
package alu_regfile_pkg;

   localparam int DEFAULT_DATAWIDTH = 32;
   localparam int ALUOP_WIDTH       = 4;
   localparam int SHAMT_WIDTH       = 5;

   localparam logic [ALUOP_WIDTH-1:0] ALUOP_AND = 4'b0000;
   localparam logic [ALUOP_WIDTH-1:0] ALUOP_OR  = 4'b0001;
   localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD = 4'b0010;
   localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUB = 4'b0110;
   localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLT = 4'b0111;
   localparam logic [ALUOP_WIDTH-1:0] ALUOP_SRL = 4'b1000;
   localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLL = 4'b1001;
   localparam logic [ALUOP_WIDTH-1:0] ALUOP_SRA = 4'b1010;
   localparam logic [ALUOP_WIDTH-1:0] ALUOP_XOR = 4'b1101;

endpackage

// File: rtl/alu_regfile_if.sv
// Bus between decode/control and the execute stage: register addresses,
// write-back data, ALU controls going in; read data, result and zero out.
interface alu_regfile_if
   import alu_regfile_pkg::*;
#(
   parameter int DATAWIDTH = DEFAULT_DATAWIDTH
);

   logic [4:0]             readReg1;
   logic [4:0]             readReg2;
   logic [4:0]             writeReg;
   logic [DATAWIDTH-1:0]   writeData;
   logic                   write;
   logic                   alu_src;
   logic [DATAWIDTH-1:0]   imm;
   logic [ALUOP_WIDTH-1:0] alu_op;
   logic [DATAWIDTH-1:0]   readData1;
   logic [DATAWIDTH-1:0]   readData2;
   logic [DATAWIDTH-1:0]   result;
   logic                   zero;

   modport master (
      output readReg1, readReg2, writeReg, writeData, write,
             alu_src, imm, alu_op,
      input  readData1, readData2, result, zero
   );

   modport slave (
      input  readReg1, readReg2, writeReg, writeData, write,
             alu_src, imm, alu_op,
      output readData1, readData2, result, zero
   );

endinterface

// File: rtl/alu_regfile_alu_unit.sv
// Purely combinational ALU. Shifts take their amount from the low five bits
// of op2; add/sub wrap silently; unknown opcodes yield zero.
module alu_unit
   import alu_regfile_pkg::*;
#(
   parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
   input  logic [DATAWIDTH-1:0]   op1,
   input  logic [DATAWIDTH-1:0]   op2,
   input  logic [ALUOP_WIDTH-1:0] alu_op,
   output logic [DATAWIDTH-1:0]   result,
   output logic                   zero
);

   logic [SHAMT_WIDTH-1:0] shamt;
   logic                   lessThan;

   assign shamt    = op2[SHAMT_WIDTH-1:0];
   assign lessThan = ($signed(op1) < $signed(op2));

   // Opcode decode; anything not listed falls through to a zero result.
   always_comb begin
      result = '0;
      unique case (alu_op)
         ALUOP_AND: result = op1 & op2;
         ALUOP_OR:  result = op1 | op2;
         ALUOP_ADD: result = op1 + op2;
         ALUOP_SUB: result = op1 - op2;
         ALUOP_SLT: result = {{(DATAWIDTH-1){1'b0}}, lessThan};
         ALUOP_SRL: result = op1 >> shamt;
         ALUOP_SLL: result = op1 << shamt;
         ALUOP_SRA: result = $unsigned($signed(op1) >>> shamt);
         ALUOP_XOR: result = op1 ^ op2;
         default:   result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_regfile.sv
// Execute-stage core: 32-entry register file with write-through bypass,
// operand select and the ALU. Everything on the output side is combinational;
// only register writes are clocked.
module alu_regfile
   import alu_regfile_pkg::*;
#(
   parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
   parameter int REGCOUNT  = 32
) (
   input  logic         clk,
   input  logic         rst,
   alu_regfile_if.slave bus
);

   logic [DATAWIDTH-1:0] regs [REGCOUNT];
   logic [DATAWIDTH-1:0] op2;
   logic                 writeActive;

   // A write only takes effect for a real, in-range destination; x0 is a sink.
   assign writeActive = bus.write && (bus.writeReg != 5'd0)
                        && (int'(bus.writeReg) < REGCOUNT);

   // Register array: async clear on reset, otherwise capture write-back data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REGCOUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (writeActive) begin
         regs[bus.writeReg] <= bus.writeData;
      end
   end

   // Read port 1: x0 is hardwired zero, a same-cycle write to rs1 is forwarded.
   always_comb begin
      bus.readData1 = '0;
      if (bus.readReg1 == 5'd0 || int'(bus.readReg1) >= REGCOUNT) begin
         bus.readData1 = '0;
      end else if (writeActive && bus.writeReg == bus.readReg1) begin
         bus.readData1 = bus.writeData;
      end else begin
         bus.readData1 = regs[bus.readReg1];
      end
   end

   // Read port 2: same rules as port 1, applied to rs2.
   always_comb begin
      bus.readData2 = '0;
      if (bus.readReg2 == 5'd0 || int'(bus.readReg2) >= REGCOUNT) begin
         bus.readData2 = '0;
      end else if (writeActive && bus.writeReg == bus.readReg2) begin
         bus.readData2 = bus.writeData;
      end else begin
         bus.readData2 = regs[bus.readReg2];
      end
   end

   assign op2 = bus.alu_src ? bus.imm : bus.readData2;

   alu_unit #(
      .DATAWIDTH (DATAWIDTH)
   ) u_alu (
      .op1    (bus.readData1),
      .op2    (op2),
      .alu_op (bus.alu_op),
      .result (bus.result),
      .zero   (bus.zero)
   );

endmodule

// File: tb/tb_alu_regfile.sv
// Bench for alu_regfile: register reset/write/bypass sequences by hand, then
// a table of ALU vectors whose expected results go through a scoreboard queue.
module tb_alu_regfile;
   import alu_regfile_pkg::*;

   localparam int DW = 32;

   typedef struct {
      logic [4:0]    rs1;
      logic [4:0]    rs2;
      logic          src;
      logic [DW-1:0] immVal;
      logic [3:0]    op;
      logic [DW-1:0] expResult;
      logic          expZero;
   } vector_t;

   typedef struct {
      logic [DW-1:0] result;
      logic          zero;
      int            idx;
   } expect_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   vector_t vectors [17];
   expect_t scoreboard [$];

   alu_regfile_if #(.DATAWIDTH(DW)) bus ();

   alu_regfile #(
      .DATAWIDTH (DW),
      .REGCOUNT  (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, actual, expected);
      end
   endtask

   // Write one register across a clock edge, then drop the enable.
   task automatic writeRegister(input logic [4:0] addr, input logic [DW-1:0] data);
      @(negedge clk);
      bus.write     = 1'b1;
      bus.writeReg  = addr;
      bus.writeData = data;
      @(posedge clk);
      #1;
      bus.write = 1'b0;
   endtask

   // Drive one table vector, queue its expectation, then pop and compare.
   task automatic applyStimulus(input int idx);
      expect_t e;
      @(negedge clk);
      bus.readReg1 = vectors[idx].rs1;
      bus.readReg2 = vectors[idx].rs2;
      bus.alu_src  = vectors[idx].src;
      bus.imm      = vectors[idx].immVal;
      bus.alu_op   = vectors[idx].op;
      scoreboard.push_back('{result: vectors[idx].expResult,
                             zero: vectors[idx].expZero, idx: idx});
      #1;
      if (scoreboard.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_empty vec%0d: actual=0 required=1", idx);
      end else begin
         e = scoreboard.pop_front();
         checkOutput($sformatf("vec%0d_result", e.idx), bus.result, e.result);
         checkOutput($sformatf("vec%0d_zero", e.idx), {31'd0, bus.zero}, {31'd0, e.zero});
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;

      vectors[0]  = '{5'd5,  5'd6, 1'b0, 32'h0,        ALUOP_SUB, 32'h0000000E, 1'b0};
      vectors[1]  = '{5'd5,  5'd6, 1'b0, 32'h0,        ALUOP_ADD, 32'h00000000, 1'b1};
      vectors[2]  = '{5'd0,  5'd0, 1'b0, 32'h0,        ALUOP_ADD, 32'h00000000, 1'b1};
      vectors[3]  = '{5'd1,  5'd0, 1'b1, 32'h4,        ALUOP_SRA, 32'hF8000000, 1'b0};
      vectors[4]  = '{5'd1,  5'd0, 1'b1, 32'h4,        ALUOP_SRL, 32'h08000000, 1'b0};
      vectors[5]  = '{5'd1,  5'd0, 1'b1, 32'h21,       ALUOP_SLL, 32'h00000000, 1'b1};
      vectors[6]  = '{5'd2,  5'd3, 1'b0, 32'h0,        ALUOP_SLT, 32'h00000001, 1'b0};
      vectors[7]  = '{5'd3,  5'd2, 1'b0, 32'h0,        ALUOP_SLT, 32'h00000000, 1'b1};
      vectors[8]  = '{5'd2,  5'd3, 1'b0, 32'h0,        ALUOP_XOR, 32'hFFFFFFFE, 1'b0};
      vectors[9]  = '{5'd2,  5'd3, 1'b0, 32'h0,        ALUOP_AND, 32'h00000001, 1'b0};
      vectors[10] = '{5'd2,  5'd3, 1'b0, 32'h0,        4'b1111,   32'h00000000, 1'b1};
      vectors[11] = '{5'd5,  5'd6, 1'b0, 32'h0,        ALUOP_OR,  32'hFFFFFFFF, 1'b0};
      vectors[12] = '{5'd10, 5'd0, 1'b1, 32'h8,        ALUOP_ADD, 32'h12345680, 1'b0};
      vectors[13] = '{5'd3,  5'd2, 1'b0, 32'h0,        ALUOP_SUB, 32'h00000002, 1'b0};
      vectors[14] = '{5'd5,  5'd6, 1'b0, 32'h0,        4'b0011,   32'h00000000, 1'b1};
      vectors[15] = '{5'd3,  5'd0, 1'b1, 32'd31,       ALUOP_SLL, 32'h80000000, 1'b0};
      vectors[16] = '{5'd6,  5'd0, 1'b1, 32'hFFFFFFE1, ALUOP_SRA, 32'hFFFFFFFC, 1'b0};

      rst           = 1'b1;
      bus.readReg1  = 5'd0;
      bus.readReg2  = 5'd0;
      bus.writeReg  = 5'd5;
      bus.writeData = 32'hAAAA5555;
      bus.write     = 1'b1;
      bus.alu_src   = 1'b0;
      bus.imm       = '0;
      bus.alu_op    = ALUOP_ADD;

      // Write attempted during reset edges must be lost.
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.write = 1'b0;
      for (int i = 0; i < 32; i++) begin
         bus.readReg1 = 5'(i);
         bus.readReg2 = 5'(31 - i);
         #1;
         checkOutput($sformatf("reset_rd1_x%0d", i), bus.readData1, 32'h0);
         checkOutput($sformatf("reset_rd2_x%0d", 31 - i), bus.readData2, 32'h0);
      end
      bus.readReg1 = 5'd5;
      bus.readReg2 = 5'd6;
      #1;
      checkOutput("reset_add_result", bus.result, 32'h0);
      checkOutput("reset_add_zero", {31'd0, bus.zero}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("x5_after_reset_write", bus.readData1, 32'h0);

      writeRegister(5'd5, 32'h00000007);
      writeRegister(5'd6, 32'hFFFFFFF9);
      bus.readReg1 = 5'd5;
      bus.readReg2 = 5'd6;
      #1;
      checkOutput("read_x5", bus.readData1, 32'h00000007);
      checkOutput("read_x6", bus.readData2, 32'hFFFFFFF9);

      // x0 protection, including no bypass of an x0 write.
      @(negedge clk);
      bus.write     = 1'b1;
      bus.writeReg  = 5'd0;
      bus.writeData = 32'hDEADBEEF;
      bus.readReg1  = 5'd0;
      #1;
      checkOutput("x0_no_bypass", bus.readData1, 32'h0);
      @(posedge clk);
      #1;
      bus.write = 1'b0;
      #1;
      checkOutput("x0_after_write", bus.readData1, 32'h0);

      // Write-through bypass before the edge, then the stored value after it.
      @(negedge clk);
      bus.write     = 1'b1;
      bus.writeReg  = 5'd10;
      bus.writeData = 32'h12345678;
      bus.readReg1  = 5'd10;
      bus.readReg2  = 5'd10;
      #1;
      checkOutput("bypass_rd1", bus.readData1, 32'h12345678);
      checkOutput("bypass_rd2", bus.readData2, 32'h12345678);
      @(posedge clk);
      #1;
      bus.write = 1'b0;
      #1;
      checkOutput("x10_stored", bus.readData1, 32'h12345678);

      writeRegister(5'd1, 32'h80000000);
      writeRegister(5'd2, 32'hFFFFFFFF);
      writeRegister(5'd3, 32'h00000001);

      for (int i = 0; i < 17; i++) begin
         applyStimulus(i);
      end

      // Mid-cycle reset clears at once; a write edge under reset is dropped.
      @(negedge clk);
      bus.readReg1 = 5'd5;
      bus.readReg2 = 5'd7;
      bus.alu_src  = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midcycle_reset_x5", bus.readData1, 32'h0);
      bus.write     = 1'b1;
      bus.writeReg  = 5'd7;
      bus.writeData = 32'h00000055;
      @(posedge clk);
      #1;
      bus.write = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("write_under_reset_x7", bus.readData2, 32'h0);

      if (scoreboard.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_leftover: actual=%0d required=0", scoreboard.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
